result_fifo: RTL and testbench
==============================

RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter WIDTH, default 5: width of the captured result word.
REQ-002 Parameter DEPTH, default 4: number of FIFO entries; power of two, at least 2.
REQ-003 Parameter CAP_CODE, default 5'd1: Z-register control code that marks a new result.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-high.
REQ-006 tz_ctl  input  5: Z-register load control from the CPU controller.
REQ-007 z_data  input  WIDTH: Z-register output from the CPU.
REQ-008 out_ready  input  1: consumer accepts the head word this cycle.
REQ-009 out_valid  output  1: head word present.
REQ-010 out_data  output  WIDTH: head word.
REQ-011 count  output  clog2(DEPTH)+1: number of stored entries.
REQ-012 full, empty  output  1 each: count==DEPTH and count==0.
REQ-013 overflow  output  1: sticky flag for a dropped capture.
REQ-014 clr_ovf  input  1: synchronous clear of overflow.

Function
REQ-015 The block SHALL register tz_ctl==CAP_CODE as match_q each cycle.
REQ-016 A capture event SHALL occur only on the rising edge of the match, defined as (tz_ctl==CAP_CODE) && !match_q.
  - A code held for N cycles yields one capture.
REQ-017 A capture SHALL write the z_data value sampled one cycle after the event edge, at the edge where match_q first reads 1.
  - This gives the Z register one cycle to load.
  - It requires a one-cycle pending flag.
REQ-018 A pop SHALL occur at a clock edge when out_valid && out_ready.
REQ-019 out_valid SHALL equal !empty, and out_data SHALL be the head entry when not empty and 0 when empty.
REQ-020 There SHALL be no bypass: a word written into an empty FIFO appears on out_data in the cycle after the write edge.
REQ-021 Write and read pointers SHALL wrap modulo DEPTH, and count SHALL be exact for DEPTH entries.
REQ-022 A write and a pop at the same edge SHALL both take effect.
  - count is unchanged.
  - This holds also when full: the pop frees a slot and the write is accepted.
REQ-023 A write when full with no pop at the same edge SHALL be dropped and SHALL set overflow.
  - Stored data and count are unchanged.
REQ-024 overflow SHALL stay set until clr_ovf or rst.
  - If clr_ovf and a new drop coincide, overflow SHALL remain 1.
REQ-025 A pop when empty SHALL be ignored.
REQ-026 If a new match edge occurs while a write is pending, the pending write SHALL complete first.
  - The new event is then processed normally.

Reset
REQ-027 While rst is high, the block SHALL asynchronously clear the following to 0:
  - write and read pointers, count, match_q, pending flag, overflow.
REQ-028 While rst is high, out_valid=0, out_data=0, empty=1, full=0, count=0.
REQ-029 Storage contents need not be cleared.
REQ-030 Reset asserted mid-operation SHALL discard all entries and any pending capture.
REQ-031 After rst deasserts, a tz_ctl already equal to CAP_CODE SHALL count as a rising edge, because match_q is 0.

Verification
REQ-032 Single capture.
  - Stimulus: tz_ctl=CAP_CODE for 3 cycles, z_data=5'd9 from the second cycle; out_ready=0.
  - Response: exactly one entry; count=1, out_valid=1, out_data=9.
REQ-033 Fill and drain.
  - Stimulus: four separate match pulses with z_data 3,7,11,15, then out_ready=1.
  - Response: full=1 after the fourth write; drain order is 3,7,11,15; empty=1 after four pops.
REQ-034 Overflow.
  - Stimulus: FIFO full, a fifth capture with z_data=20, out_ready=0.
  - Response: overflow=1, count=4, 20 never appears on out_data.
  - Then clr_ovf for 1 cycle: overflow=0.
REQ-035 Simultaneous write and pop when full.
  - Stimulus: FIFO full with 1,2,3,4; capture 5 at the same edge as a pop.
  - Response: count stays 4, overflow=0, drain order 2,3,4,5.
REQ-036 Asynchronous reset.
  - Stimulus: 2 entries stored and a capture pending; rst pulsed between clock edges.
  - Response: count=0, out_valid=0, out_data=0 immediately; no write after release.
REQ-037 Pointer wrap.
  - Stimulus: 10 alternating capture/pop pairs with values 0..9.
  - Response: outputs 0..9 in order; count never exceeds 1.

Source files
------------

// File: rtl/result_fifo.sv
// Result capture FIFO: snoops the CPU Z-register load control and queues the
// Z value one cycle after each rising edge of the capture code.
module result_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter logic [4:0] CAP_CODE = 5'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 tz_ctl,
  input  logic [WIDTH-1:0]           z_data,
  input  logic                       out_ready,
  input  logic                       clr_ovf,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             match_q, pending_reg, overflow_reg;

  logic match, cap_event, pop, write_ok, drop;

  assign match     = (tz_ctl == CAP_CODE);
  assign cap_event = match && !match_q;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_reg];
  assign count     = count_reg;
  assign overflow  = overflow_reg;

  // A pop at the same edge frees the slot, so a write into a full FIFO is
  // only dropped when nothing leaves.
  assign pop      = out_valid && out_ready;
  assign write_ok = pending_reg && (!full || pop);
  assign drop     = pending_reg && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q      <= 1'b0;
      pending_reg  <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      match_q     <= match;
      pending_reg <= cap_event;
      if (write_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({write_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A drop wins over a coincident clear.
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (write_ok) mem[wr_ptr_reg] <= z_data;
  end

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo: capture timing, fill/drain, overflow,
// full write+pop, asynchronous reset and pointer wrap.
module tb_result_fifo;

  localparam logic [4:0] CAP = 5'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] tz_ctl = 5'd0;
  logic [4:0] z_data = 5'd0;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [4:0] out_data;
  logic [2:0] count;
  logic       full, empty, overflow;

  int checks = 0;
  int failures = 0;

  result_fifo #(.WIDTH(5), .DEPTH(4), .CAP_CODE(CAP)) dut (
    .clk(clk), .rst(rst), .tz_ctl(tz_ctl), .z_data(z_data),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .out_data(out_data), .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle code pulse; value presented in the following cycle is written.
  task automatic capture(input logic [4:0] v, input logic pop_too);
    tz_ctl = CAP; z_data = 5'd0;
    step();
    tz_ctl = 5'd0; z_data = v; out_ready = pop_too;
    step();
    z_data = 5'd0; out_ready = 1'b0;
  endtask

  task automatic drain4(input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] d);
    logic [4:0] exp [4];
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain[%0d]", i), out_data, exp[i]);
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", empty, 1);
  endtask

  initial begin
    #1;
    step();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    #4 rst = 1'b0;
    step();

    // Code held three cycles, data valid from the second cycle.
    tz_ctl = CAP;
    step();
    z_data = 5'd9;
    step();
    step();
    tz_ctl = 5'd0;
    step();
    step();
    check("single_count", count, 1);
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 9);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_popped", empty, 1);

    // Fill and drain, plus one ignored pop when empty.
    capture(5'd3, 1'b0); capture(5'd7, 1'b0); capture(5'd11, 1'b0);
    check("fill_full3", full, 0);
    capture(5'd15, 1'b0);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    drain4(5'd3, 5'd7, 5'd11, 5'd15);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("empty_pop_count", count, 0);

    // Overflow: drop, clear, drop coinciding with clear, clear again.
    capture(5'd3, 1'b0); capture(5'd7, 1'b0); capture(5'd11, 1'b0); capture(5'd15, 1'b0);
    capture(5'd20, 1'b0);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 4);
    check("ovf_head", out_data, 3);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clear", overflow, 0);
    tz_ctl = CAP;
    step();
    tz_ctl = 5'd0; z_data = 5'd21; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0; z_data = 5'd0;
    check("ovf_clr_vs_drop", overflow, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clear2", overflow, 0);
    drain4(5'd3, 5'd7, 5'd11, 5'd15);

    // Write and pop at the same edge while full.
    capture(5'd1, 1'b0); capture(5'd2, 1'b0); capture(5'd3, 1'b0); capture(5'd4, 1'b0);
    capture(5'd5, 1'b1);
    check("wp_count", count, 4);
    check("wp_ovf", overflow, 0);
    drain4(5'd2, 5'd3, 5'd4, 5'd5);

    // Asynchronous reset between edges with a capture pending.
    capture(5'd1, 1'b0); capture(5'd2, 1'b0);
    tz_ctl = CAP;
    step();
    tz_ctl = 5'd0; z_data = 5'd9;
    #2 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_empty", empty, 1);
    #1 rst = 1'b0;
    step();
    step();
    z_data = 5'd0;
    check("arst_no_write", count, 0);

    // Pointer wrap over ten capture/pop pairs.
    for (int i = 0; i < 10; i++) begin
      capture(5'(i), 1'b0);
      check($sformatf("wrap_count[%0d]", i), count, 1);
      check($sformatf("wrap_data[%0d]", i), out_data, i);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("wrap_empty[%0d]", i), count, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
